// File: rtl/core_trap_ctrl.sv
// ---------------------------------------------------------------------------
// core_trap_ctrl
//   Sequences trap entry (exception or interrupt) and trap return (MRET/SRET)
//   against the CSR file. It picks M-mode or S-mode handling from
//   medeleg/mideleg, then drives the CSR file's implicit write ports in a
//   fixed order (cause group, then status group). Finally it hands the new PC
//   to fetch over a valid/ready redirect handshake.
//
//   Timeline (registered outputs):
//     trap : req_ack @N, epc/cause/tval @N+1, mstatus/prv @N+2,
//            redirect_valid from N+3
//     xRET : req_ack @N, mstatus/prv @N+1, redirect_valid from N+2
//
// Ports
//   clk, rst                 core clock, asynchronous active-high reset
//   trap_req/_is_intr/_code/_pc/_tval   trap request and its operands
//   ret_req, ret_is_mret     xRET request (1=MRET, 0=SRET)
//   req_ack                  one-cycle pulse: request accepted, operands captured
//   busy                     high whenever a sequence is in flight
//   prv_mode                 current privilege (U=0, S=1, M=3)
//   csr_*_ff                 current mstatus, delegation masks, vectors, xepc
//   csr_*_wd / csr_*_we      implicit CSR writes (sepc, scause, stval, mepc,
//                            mcause, mstatus)
//   prv_mode_wd/_we          new privilege level
//   redirect_valid/_ready/_pc  redirect handshake to fetch
// ---------------------------------------------------------------------------
module core_trap_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_req,
  input  logic        trap_is_intr,
  input  logic [4:0]  trap_code,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_tval,
  input  logic        ret_req,
  input  logic        ret_is_mret,
  output logic        req_ack,
  output logic        busy,
  input  logic [1:0]  prv_mode,
  input  logic [31:0] csr_mstatus_ff,
  input  logic [31:0] csr_medeleg_ff,
  input  logic [31:0] csr_mideleg_ff,
  input  logic [31:0] csr_mtvec_ff,
  input  logic [31:0] csr_stvec_ff,
  input  logic [31:0] csr_mepc_ff,
  input  logic [31:0] csr_sepc_ff,
  output logic [31:0] csr_sepc_wd,
  output logic        csr_sepc_we,
  output logic [31:0] csr_scause_wd,
  output logic        csr_scause_we,
  output logic [31:0] csr_stval_wd,
  output logic        csr_stval_we,
  output logic [31:0] csr_mepc_wd,
  output logic        csr_mepc_we,
  output logic [31:0] csr_mcause_wd,
  output logic        csr_mcause_we,
  output logic [31:0] csr_mstatus_wd,
  output logic        csr_mstatus_we,
  output logic [1:0]  prv_mode_wd,
  output logic        prv_mode_we,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc
);

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAUSE,
    ST_STATUS,
    ST_REDIRECT
  } state_e;

  localparam logic [1:0] PRV_U = 2'd0;
  localparam logic [1:0] PRV_S = 2'd1;
  localparam logic [1:0] PRV_M = 2'd3;

  // mstatus bit positions
  localparam int SIE    = 1;
  localparam int MIE    = 3;
  localparam int SPIE   = 5;
  localparam int MPIE   = 7;
  localparam int SPP    = 8;
  localparam int MPP_LO = 11;
  localparam int MPP_HI = 12;
  localparam int MPRV   = 17;

  state_e     state;

  // Operands captured in the accept cycle
  logic       is_trap_q;
  logic       is_intr_q;
  logic       is_mret_q;
  logic       deleg_q;
  logic [4:0] code_q;
  logic [1:0] prv_q;
  word_t      pc_q;
  word_t      tval_q;

  logic       deleg_now;
  word_t      status_next;
  logic [1:0] prv_next;
  word_t      pc_next;
  word_t      tvec;
  word_t      cause_w;

  // Delegation is only possible below M; M-mode traps never go to S.
  assign deleg_now = (prv_mode != PRV_M) &&
                     (trap_is_intr ? csr_mideleg_ff[trap_code]
                                   : csr_medeleg_ff[trap_code]);

  assign cause_w = {is_intr_q, 26'd0, code_q};

  // New mstatus / privilege / target PC, evaluated while in ST_STATUS
  // against the live csr_mstatus_ff.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    status_next = csr_mstatus_ff;
    prv_next    = PRV_M;
    tvec        = deleg_q ? csr_stvec_ff : csr_mtvec_ff;
    pc_next     = '0;
    if (is_trap_q) begin
      // Vectored mode (tvec[1:0]==1) only applies to interrupts.
      pc_next = {tvec[31:2], 2'b00};
      if (tvec[1:0] == 2'b01 && is_intr_q)
        pc_next = {tvec[31:2], 2'b00} + {25'd0, code_q, 2'b00};
      if (deleg_q) begin
        status_next[SPIE] = csr_mstatus_ff[SIE];
        status_next[SIE]  = 1'b0;
        status_next[SPP]  = prv_q[0];
        prv_next          = PRV_S;
      end else begin
        status_next[MPIE]          = csr_mstatus_ff[MIE];
        status_next[MIE]           = 1'b0;
        status_next[MPP_HI:MPP_LO] = prv_q;
        prv_next                   = PRV_M;
      end
    end else if (is_mret_q) begin
      status_next[MIE]           = csr_mstatus_ff[MPIE];
      status_next[MPIE]          = 1'b1;
      status_next[MPP_HI:MPP_LO] = PRV_U;
      prv_next                   = csr_mstatus_ff[MPP_HI:MPP_LO];
      // Returning to anything below M drops MPRV.
      if (csr_mstatus_ff[MPP_HI:MPP_LO] != PRV_M)
        status_next[MPRV] = 1'b0;
      pc_next = {csr_mepc_ff[31:2], 2'b00};
    end else begin
      status_next[SIE]  = csr_mstatus_ff[SPIE];
      status_next[SPIE] = 1'b1;
      status_next[SPP]  = 1'b0;
      status_next[MPRV] = 1'b0;
      prv_next          = {1'b0, csr_mstatus_ff[SPP]};
      pc_next           = {csr_sepc_ff[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      is_trap_q      <= 1'b0;
      is_intr_q      <= 1'b0;
      is_mret_q      <= 1'b0;
      deleg_q        <= 1'b0;
      code_q         <= '0;
      prv_q          <= PRV_U;
      pc_q           <= '0;
      tval_q         <= '0;
      req_ack        <= 1'b0;
      busy           <= 1'b0;
      csr_sepc_wd    <= '0;
      csr_sepc_we    <= 1'b0;
      csr_scause_wd  <= '0;
      csr_scause_we  <= 1'b0;
      csr_stval_wd   <= '0;
      csr_stval_we   <= 1'b0;
      csr_mepc_wd    <= '0;
      csr_mepc_we    <= 1'b0;
      csr_mcause_wd  <= '0;
      csr_mcause_we  <= 1'b0;
      csr_mstatus_wd <= '0;
      csr_mstatus_we <= 1'b0;
      prv_mode_wd    <= PRV_U;
      prv_mode_we    <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments; the pulse
      // outputs default low here so each is high for exactly one cycle.
      req_ack        <= 1'b0;
      csr_sepc_we    <= 1'b0;
      csr_scause_we  <= 1'b0;
      csr_stval_we   <= 1'b0;
      csr_mepc_we    <= 1'b0;
      csr_mcause_we  <= 1'b0;
      csr_mstatus_we <= 1'b0;
      prv_mode_we    <= 1'b0;

      case (state)
        ST_IDLE: begin
          // A trap outranks a simultaneous xRET; the xRET stays unacked.
          if (trap_req) begin
            req_ack   <= 1'b1;
            busy      <= 1'b1;
            is_trap_q <= 1'b1;
            is_intr_q <= trap_is_intr;
            code_q    <= trap_code;
            pc_q      <= trap_pc;
            tval_q    <= trap_tval;
            prv_q     <= prv_mode;
            deleg_q   <= deleg_now;
            state     <= ST_CAUSE;
          end else if (ret_req) begin
            req_ack   <= 1'b1;
            busy      <= 1'b1;
            is_trap_q <= 1'b0;
            is_mret_q <= ret_is_mret;
            state     <= ST_STATUS;
          end
        end

        ST_CAUSE: begin
          if (deleg_q) begin
            csr_sepc_wd   <= pc_q;
            csr_sepc_we   <= 1'b1;
            csr_scause_wd <= cause_w;
            csr_scause_we <= 1'b1;
            csr_stval_wd  <= tval_q;
            csr_stval_we  <= 1'b1;
          end else begin
            csr_mepc_wd   <= pc_q;
            csr_mepc_we   <= 1'b1;
            csr_mcause_wd <= cause_w;
            csr_mcause_we <= 1'b1;
          end
          state <= ST_STATUS;
        end

        ST_STATUS: begin
          csr_mstatus_wd <= status_next;
          csr_mstatus_we <= 1'b1;
          prv_mode_wd    <= prv_next;
          prv_mode_we    <= 1'b1;
          redirect_pc    <= pc_next;
          state          <= ST_REDIRECT;
        end

        ST_REDIRECT: begin
          // First cycle here raises valid; afterwards hold pc until accepted.
          if (!redirect_valid) begin
            redirect_valid <= 1'b1;
          end else if (redirect_ready) begin
            redirect_valid <= 1'b0;
            busy           <= 1'b0;
            state          <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
